spike_edge_encoder: RTL and testbench
=====================================

# spike_edge_encoder

Parametrised, multi-channel edge-to-spike encoder for the SNN input path. Sits between the raw input spike trains and the hidden layer. Per channel it:

- synchronises the input,
- detects rising, falling or both edges (selected at runtime),
- enforces a programmable refractory period,
- accumulates a saturating spike count for rate monitoring.

Boot-mode gating keeps the block silent while weights load.

## Interface
Parameters:
- N_CH, 8, number of input channels
- SYNC_STAGES, 2, input synchroniser depth; 0 means the input is already synchronous
- REFR_W, 4, refractory counter width
- CNT_W, 8, per-channel spike counter width

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- boot_mode  in  1  high = weight load in progress; suppress spike output
- edge_mode  in  2  edge select: 00 rise, 01 fall, 10 both, 11 disabled
- refr_len  in  REFR_W  refractory length in cycles after an emitted spike; 0 = none
- cnt_clear  in  1  synchronous clear of all spike counters
- input_signal  in  N_CH  raw spike trains
- edge_spike  out  N_CH  one-cycle spike per accepted edge, registered
- spike_any  out  1  registered OR of the next-cycle edge_spike value (same cycle as edge_spike)
- spike_count  out  N_CH*CNT_W  channel i at bits [i*CNT_W +: CNT_W]
- count_sat  out  N_CH  channel counter has reached all-ones

## Operation
- **Sync chain:** SYNC_STAGES flops per channel producing s.
- **Previous-value register:** p <= s every non-reset cycle, including during boot_mode. This prevents a spurious edge on boot exit.
- **Raw edge:**
  - rise = s & ~p
  - fall = ~s & p
  - both = s ^ p
  - disabled = 0
- **Refractory counter r per channel:**
  - if r != 0: the raw edge is suppressed and r decrements.
  - else a raw edge is accepted: edge_spike asserts next cycle and r loads refr_len.
  - A refr_len change takes effect at the next load only; an in-flight count is unaffected.
- **boot_mode = 1:**
  - edge_spike and spike_any are driven 0.
  - r holds and spike_count holds.
  - Sync chain and p keep tracking the input.
- **Spike counter:**
  - increments by 1 per accepted spike, saturating at 2^CNT_W-1.
  - count_sat is a registered flag, equal to (count == all-ones).
- **cnt_clear:** has priority over increment for the old value, but a same-cycle accepted spike is counted. Resulting count is 1, otherwise 0.
- **edge_mode changes:** take effect immediately on the next comparison; no pipeline flush.
- **Reset values:**
  - edge_spike = 0, spike_any = 0
  - all counts = 0, count_sat = 0
  - r = 0, p = 0, sync flops = 0
- **Reset mid-refractory:** r returns to 0; the first edge after reset is accepted.

## Timing
- **Latency:** input transition at rising edge k gives edge_spike high during cycle k+SYNC_STAGES+1, for exactly 1 cycle.
- **Refractory window:** a spike emitted in cycle t blocks raw edges in cycles t .. t+refr_len-1 (evaluation cycles). The earliest next spike is cycle t+refr_len+1.
- **Counter update:** spike_count updates in the same cycle edge_spike asserts; count_sat follows one cycle later.
- **Back-to-back toggles:** with edge_mode = both and refr_len = 0, a 1-cycle-alternating input gives edge_spike high every cycle.
- **Channel independence:** channels are fully independent; there is no arbitration.

## Structure
- **Package spike_pkg:**
  - edge-mode localparams: EDGE_RISE = 2'b00, EDGE_FALL = 2'b01, EDGE_BOTH = 2'b10, EDGE_OFF = 2'b11
  - default widths
- **Sub-module spike_edge_channel:**
  - contents: sync chain, p, r, counter, sat flag
  - instantiated N_CH times via generate
- **Top level:**
  - only: spike_any OR-reduction and spike_count packing.

## Test plan
- **Rise mode after reset** (SYNC_STAGES = 2, refr_len = 0, edge_mode = 00): drive ch0 0 -> 1 at cycle 10. Expect edge_spike[0] high at cycle 13 only, spike_count[0] = 1, spike_any high at cycle 13.
- **Refractory suppression** (refr_len = 3, edge_mode = 10, SYNC_STAGES = 0): ch3 toggles every cycle from cycle 5. Expect spikes at 6, 10, 14, ...; count increments every 4 cycles.
- **boot_mode gating:** hold boot_mode = 1 while ch1 rises at cycle 8; release at cycle 12 with ch1 still high. Expect no edge_spike[1] at any point; count stays 0.
- **Saturation and clear** (CNT_W = 4): 20 accepted spikes on ch2. Expect count = 15 and count_sat = 1. Then cnt_clear in the same cycle as an accepted spike gives count = 1 and count_sat = 0 next cycle.
- **Fall/off modes:** edge_mode = 01 with a 1 -> 0 on ch7 gives one spike and no spike on 0 -> 1. edge_mode = 11 gives no spikes for any activity.
- **Reset mid-refractory:** refr_len = 15, spike on ch0, assert rst two cycles later, deassert, then rise again. Expect the spike accepted at normal latency and count = 1.

Source files
------------

// File: rtl/spike_edge_encoder_pkg.sv
// ---------------------------------------------------------------------------
// spike_pkg: edge-mode encodings, default widths and the raw edge helper. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spike_pkg;

   localparam logic [1:0] EDGE_RISE = 2'b00;
   localparam logic [1:0] EDGE_FALL = 2'b01;
   localparam logic [1:0] EDGE_BOTH = 2'b10;
   localparam logic [1:0] EDGE_OFF  = 2'b11;

   localparam int DEF_N_CH        = 8;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_REFR_W      = 4;
   localparam int DEF_CNT_W       = 8;

   function automatic logic edge_detect(input logic [1:0] mode,
                                        input logic       s,
                                        input logic       p);
      logic e;
      e = 1'b0;
      case (mode)
         EDGE_RISE: e = s & ~p;
         EDGE_FALL: e = ~s & p;
         EDGE_BOTH: e = s ^ p;
         default:   e = 1'b0;
      endcase
      return e;
   endfunction

endpackage

`default_nettype wire

// File: rtl/spike_edge_encoder_if.sv
// ---------------------------------------------------------------------------
// spike_edge_encoder_if: control, input trains and spike/count outputs. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface spike_edge_encoder_if #(
   parameter int N_CH   = 8,
   parameter int REFR_W = 4,
   parameter int CNT_W  = 8
);
   logic                    boot_mode;
   logic [1:0]              edge_mode;
   logic [REFR_W-1:0]       refr_len;
   logic                    cnt_clear;
   logic [N_CH-1:0]         input_signal;
   logic [N_CH-1:0]         edge_spike;
   logic                    spike_any;
   logic [N_CH*CNT_W-1:0]   spike_count;
   logic [N_CH-1:0]         count_sat;

   modport master (
      output boot_mode, edge_mode, refr_len, cnt_clear, input_signal,
      input  edge_spike, spike_any, spike_count, count_sat
   );

   modport slave (
      input  boot_mode, edge_mode, refr_len, cnt_clear, input_signal,
      output edge_spike, spike_any, spike_count, count_sat
   );
endinterface

`default_nettype wire

// File: rtl/spike_edge_encoder_channel.sv
// ---------------------------------------------------------------------------
// spike_edge_channel: per-channel sync, edge detect, refractory and counter. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spike_edge_channel
   import spike_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int REFR_W      = DEF_REFR_W,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              boot_mode_i,
   input  wire logic [1:0]        edge_mode_i,
   input  wire logic [REFR_W-1:0] refr_len_i,
   input  wire logic              cnt_clear_i,
   input  wire logic              input_i,
   output      logic              spike_o,
   output      logic              accept_o,
   output      logic [CNT_W-1:0]  count_o,
   output      logic              sat_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              s_w;
   logic              raw_w;
   logic              accept_w;
   logic              p_q;
   logic              spike_q;
   logic              sat_q;
   logic [REFR_W-1:0] r_q, r_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s_w = input_i;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= input_i;
               for (int k = 1; k < SYNC_STAGES; k++) begin
                  sync_q[k] <= sync_q[k-1];
               end
            end
         end
         assign s_w = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   always_comb begin
      raw_w    = edge_detect(edge_mode_i, s_w, p_q);
      accept_w = raw_w & ~boot_mode_i & (r_q == '0);
   end

   // The refractory counter only loads on an accepted edge, so refr_len
   // changes never disturb a count already in flight.
   always_comb begin
      r_d = r_q;
      if (!boot_mode_i) begin
         if (r_q != '0) begin
            r_d = r_q - REFR_W'(1);
         end else if (raw_w) begin
            r_d = refr_len_i;
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clear_i) begin
         cnt_d = CNT_W'(accept_w);
      end else if (accept_w && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // p follows s even in boot mode so leaving boot never fakes an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_q     <= 1'b0;
         r_q     <= '0;
         cnt_q   <= '0;
         spike_q <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         p_q     <= s_w;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         spike_q <= accept_w;
         sat_q   <= (cnt_q == CNT_MAX);
      end
   end

   assign spike_o  = spike_q;
   assign accept_o = accept_w;
   assign count_o  = cnt_q;
   assign sat_o    = sat_q;

endmodule

`default_nettype wire

// File: rtl/spike_edge_encoder.sv
// ---------------------------------------------------------------------------
// spike_edge_encoder: N_CH edge-to-spike channels plus the spike_any flag. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spike_edge_encoder
   import spike_pkg::*;
#(
   parameter int N_CH        = DEF_N_CH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int REFR_W      = DEF_REFR_W,
   parameter int CNT_W       = DEF_CNT_W
) (
   input wire logic           clk,
   input wire logic           rst,
   spike_edge_encoder_if.slave bus
);

   logic [N_CH-1:0] accept_w;
   logic            spike_any_d;
   logic            spike_any_q;

   generate
      for (genvar i = 0; i < N_CH; i++) begin : g_ch
         spike_edge_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .REFR_W      (REFR_W),
            .CNT_W       (CNT_W)
         ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .boot_mode_i (bus.boot_mode),
            .edge_mode_i (bus.edge_mode),
            .refr_len_i  (bus.refr_len),
            .cnt_clear_i (bus.cnt_clear),
            .input_i     (bus.input_signal[i]),
            .spike_o     (bus.edge_spike[i]),
            .accept_o    (accept_w[i]),
            .count_o     (bus.spike_count[i*CNT_W +: CNT_W]),
            .sat_o       (bus.count_sat[i])
         );
      end
   endgenerate

   // Registered from the accept vector so it lines up with edge_spike.
   always_comb begin
      spike_any_d = |accept_w;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         spike_any_q <= 1'b0;
      end else begin
         spike_any_q <= spike_any_d;
      end
   end

   assign bus.spike_any = spike_any_q;

endmodule

`default_nettype wire

// File: tb/tb_spike_edge_encoder.sv
// ---------------------------------------------------------------------------
// tb_spike_edge_encoder: directed checks on a synced (CNT_W=4) and an unsynced instance. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spike_edge_encoder;
   import spike_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   spike_edge_encoder_if #(.N_CH(8), .REFR_W(4), .CNT_W(4)) ifa ();
   spike_edge_encoder_if #(.N_CH(8), .REFR_W(4), .CNT_W(8)) ifb ();

   spike_edge_encoder #(.N_CH(8), .SYNC_STAGES(2), .REFR_W(4), .CNT_W(4)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   spike_edge_encoder #(.N_CH(8), .SYNC_STAGES(0), .REFR_W(4), .CNT_W(8)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      checks++; if (ifa.edge_spike !== 8'h00) begin errors++; $display("FAIL reset_spike_a: got %h expected 00", ifa.edge_spike); end
      checks++; if (ifa.spike_any !== 1'b0) begin errors++; $display("FAIL reset_any_a: got %b expected 0", ifa.spike_any); end
      checks++; if (ifa.spike_count !== 32'h0) begin errors++; $display("FAIL reset_count_a: got %h expected 0", ifa.spike_count); end
      checks++; if (ifa.count_sat !== 8'h00) begin errors++; $display("FAIL reset_sat_a: got %h expected 00", ifa.count_sat); end
      checks++; if (ifb.spike_count !== 64'h0) begin errors++; $display("FAIL reset_count_b: got %h expected 0", ifb.spike_count); end
      checks++; if (ifb.edge_spike !== 8'h00) begin errors++; $display("FAIL reset_spike_b: got %h expected 00", ifb.edge_spike); end
   endtask

   task automatic test_rise();
      logic [7:0] exp_v;
      ifa.edge_mode = EDGE_RISE;
      ifa.refr_len  = 4'd0;
      ifa.input_signal[0] = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         tick();
         exp_v = (n == 3) ? 8'h01 : 8'h00;
         checks++; if (ifa.edge_spike !== exp_v) begin errors++; $display("FAIL rise_spike t%0d: got %h expected %h", n, ifa.edge_spike, exp_v); end
         checks++; if (ifa.spike_any !== exp_v[0]) begin errors++; $display("FAIL rise_any t%0d: got %b expected %b", n, ifa.spike_any, exp_v[0]); end
         if (n == 3) begin
            checks++; if (ifa.spike_count[3:0] !== 4'd1) begin errors++; $display("FAIL rise_count: got %0d expected 1", ifa.spike_count[3:0]); end
         end
      end
      ifa.input_signal[0] = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         tick();
         checks++; if (ifa.edge_spike !== 8'h00) begin errors++; $display("FAIL rise_ignore_fall t%0d: got %h expected 00", n, ifa.edge_spike); end
      end
      ifa.input_signal[5:4] = 2'b11;
      repeat (3) tick();
      checks++; if (ifa.edge_spike !== 8'h30) begin errors++; $display("FAIL rise_multi: got %h expected 30", ifa.edge_spike); end
      checks++; if (ifa.spike_count[19:16] !== 4'd1 || ifa.spike_count[23:20] !== 4'd1) begin
         errors++; $display("FAIL rise_multi_count: got %h expected 11", ifa.spike_count[23:16]); end
      checks++; if (ifa.spike_count[3:0] !== 4'd1) begin errors++; $display("FAIL rise_ch0_hold: got %0d expected 1", ifa.spike_count[3:0]); end
      tick();
      checks++; if (ifa.edge_spike !== 8'h00) begin errors++; $display("FAIL rise_one_cycle: got %h expected 00", ifa.edge_spike); end
   endtask

   task automatic test_refractory();
      logic exp_s;
      int   exp_c;
      ifb.edge_mode = EDGE_BOTH;
      ifb.refr_len  = 4'd3;
      ifb.input_signal[3] = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         tick();
         exp_s = ((n % 4) == 1);
         exp_c = (n + 3) / 4;
         checks++; if (ifb.edge_spike[3] !== exp_s) begin errors++; $display("FAIL refr_spike t%0d: got %b expected %b", n, ifb.edge_spike[3], exp_s); end
         checks++; if (int'(ifb.spike_count[31:24]) != exp_c) begin errors++; $display("FAIL refr_count t%0d: got %0d expected %0d", n, ifb.spike_count[31:24], exp_c); end
         if (n < 16) ifb.input_signal[3] = ~ifb.input_signal[3];
      end
   endtask

   task automatic test_back_to_back();
      ifb.refr_len = 4'd0;
      ifb.input_signal[1] = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         tick();
         checks++; if (ifb.edge_spike[1] !== 1'b1) begin errors++; $display("FAIL b2b_spike t%0d: got %b expected 1", n, ifb.edge_spike[1]); end
         checks++; if (int'(ifb.spike_count[15:8]) != n) begin errors++; $display("FAIL b2b_count t%0d: got %0d expected %0d", n, ifb.spike_count[15:8], n); end
         checks++; if (ifb.spike_any !== 1'b1) begin errors++; $display("FAIL b2b_any t%0d: got %b expected 1", n, ifb.spike_any); end
         if (n < 8) ifb.input_signal[1] = ~ifb.input_signal[1];
      end
      tick();
      checks++; if (ifb.edge_spike[1] !== 1'b0) begin errors++; $display("FAIL b2b_stop: got %b expected 0", ifb.edge_spike[1]); end
   endtask

   task automatic test_boot();
      ifa.edge_mode = EDGE_RISE;
      ifa.boot_mode = 1'b1;
      tick();
      ifa.input_signal[1] = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         tick();
         checks++; if (ifa.edge_spike[1] !== 1'b0) begin errors++; $display("FAIL boot_spike t%0d: got %b expected 0", n, ifa.edge_spike[1]); end
         checks++; if (ifa.spike_any !== 1'b0) begin errors++; $display("FAIL boot_any t%0d: got %b expected 0", n, ifa.spike_any); end
      end
      ifa.boot_mode = 1'b0;
      for (int n = 1; n <= 6; n++) begin
         tick();
         checks++; if (ifa.edge_spike[1] !== 1'b0) begin errors++; $display("FAIL boot_exit t%0d: got %b expected 0", n, ifa.edge_spike[1]); end
      end
      checks++; if (ifa.spike_count[7:4] !== 4'd0) begin errors++; $display("FAIL boot_count: got %0d expected 0", ifa.spike_count[7:4]); end
   endtask

   task automatic test_saturation();
      ifa.edge_mode = EDGE_BOTH;
      ifa.refr_len  = 4'd0;
      for (int n = 0; n < 20; n++) begin
         ifa.input_signal[2] = ~ifa.input_signal[2];
         tick();
      end
      repeat (4) tick();
      checks++; if (ifa.spike_count[11:8] !== 4'd15) begin errors++; $display("FAIL sat_count: got %0d expected 15", ifa.spike_count[11:8]); end
      checks++; if (ifa.count_sat !== 8'h04) begin errors++; $display("FAIL sat_flag: got %h expected 04", ifa.count_sat); end
      ifa.input_signal[2] = ~ifa.input_signal[2];
      repeat (2) tick();
      ifa.cnt_clear = 1'b1;
      tick();
      ifa.cnt_clear = 1'b0;
      checks++; if (ifa.edge_spike[2] !== 1'b1) begin errors++; $display("FAIL clr_spike: got %b expected 1", ifa.edge_spike[2]); end
      checks++; if (ifa.spike_count[11:8] !== 4'd1) begin errors++; $display("FAIL clr_count_spiking: got %0d expected 1", ifa.spike_count[11:8]); end
      checks++; if (ifa.spike_count[3:0] !== 4'd0) begin errors++; $display("FAIL clr_count_idle: got %0d expected 0", ifa.spike_count[3:0]); end
      checks++; if (ifa.count_sat[2] !== 1'b1) begin errors++; $display("FAIL clr_sat_lag: got %b expected 1", ifa.count_sat[2]); end
      tick();
      checks++; if (ifa.count_sat !== 8'h00) begin errors++; $display("FAIL clr_sat: got %h expected 00", ifa.count_sat); end
      checks++; if (ifa.spike_count[11:8] !== 4'd1) begin errors++; $display("FAIL clr_count_hold: got %0d expected 1", ifa.spike_count[11:8]); end
   endtask

   task automatic test_fall_off();
      ifa.edge_mode = EDGE_FALL;
      ifa.input_signal[7] = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         tick();
         checks++; if (ifa.edge_spike[7] !== 1'b0) begin errors++; $display("FAIL fall_on_rise t%0d: got %b expected 0", n, ifa.edge_spike[7]); end
      end
      ifa.input_signal[7] = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         tick();
         checks++; if (ifa.edge_spike[7] !== (n == 3)) begin errors++; $display("FAIL fall_spike t%0d: got %b expected %b", n, ifa.edge_spike[7], (n == 3)); end
      end
      checks++; if (ifa.spike_count[31:28] !== 4'd1) begin errors++; $display("FAIL fall_count: got %0d expected 1", ifa.spike_count[31:28]); end
      ifa.edge_mode = EDGE_OFF;
      ifa.input_signal[7] = 1'b1;
      repeat (5) tick();
      ifa.input_signal[7] = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         tick();
         checks++; if (ifa.edge_spike !== 8'h00) begin errors++; $display("FAIL off_spike t%0d: got %h expected 00", n, ifa.edge_spike); end
      end
      checks++; if (ifa.spike_count[31:28] !== 4'd1) begin errors++; $display("FAIL off_count: got %0d expected 1", ifa.spike_count[31:28]); end
   endtask

   task automatic test_reset_mid_refr();
      ifa.edge_mode = EDGE_RISE;
      ifa.refr_len  = 4'd15;
      ifa.input_signal[0] = 1'b1;
      repeat (3) tick();
      checks++; if (ifa.edge_spike[0] !== 1'b1) begin errors++; $display("FAIL mid_first_spike: got %b expected 1", ifa.edge_spike[0]); end
      repeat (2) tick();
      rst = 1'b1;
      ifa.input_signal[0] = 1'b0;
      repeat (2) tick();
      checks++; if (ifa.spike_count !== 32'h0) begin errors++; $display("FAIL mid_reset_count: got %h expected 0", ifa.spike_count); end
      checks++; if (ifa.count_sat !== 8'h00) begin errors++; $display("FAIL mid_reset_sat: got %h expected 00", ifa.count_sat); end
      rst = 1'b0;
      repeat (4) tick();
      ifa.input_signal[0] = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         tick();
         checks++; if (ifa.edge_spike[0] !== (n == 3)) begin errors++; $display("FAIL mid_after_spike t%0d: got %b expected %b", n, ifa.edge_spike[0], (n == 3)); end
      end
      checks++; if (ifa.spike_count[3:0] !== 4'd1) begin errors++; $display("FAIL mid_after_count: got %0d expected 1", ifa.spike_count[3:0]); end
   endtask

   initial begin
      rst = 1'b1;
      ifa.boot_mode = 1'b0; ifa.edge_mode = EDGE_RISE; ifa.refr_len = '0;
      ifa.cnt_clear = 1'b0; ifa.input_signal = '0;
      ifb.boot_mode = 1'b0; ifb.edge_mode = EDGE_RISE; ifb.refr_len = '0;
      ifb.cnt_clear = 1'b0; ifb.input_signal = '0;
      test_reset();
      test_rise();
      test_refractory();
      test_back_to_back();
      test_boot();
      test_saturation();
      test_fall_off();
      test_reset_mid_refr();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
